// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct constants, ALU op encodings and register indices shared by the pipeline
package cpu_pkg;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_XORI = 6'h0e;
    localparam logic [5:0] OP_LUI  = 6'h0f;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [4:0] REG_RA  = 5'd31;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;
endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: IF/ID, bypass and write-back inputs plus redirect, stall and ID/EX outputs of the decode stage
interface id_stage_if;
    logic [31:0] if_id_instruction, if_id_pc4;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_write, ex_mem_mem_read;
    logic [31:0] ex_mem_result;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        jump, stall;
    logic [31:0] jump_pc;
    logic [31:0] id_ex_a, id_ex_b, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg;
    modport master (
        output if_id_instruction, if_id_pc4, ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_result,
               wb_write, wb_rd, wb_data,
        input  jump, jump_pc, stall, id_ex_a, id_ex_b, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt,
               id_ex_alu_op, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg
    );
    modport slave (
        input  if_id_instruction, if_id_pc4, ex_mem_rd, ex_mem_reg_write, ex_mem_mem_read, ex_mem_result,
               wb_write, wb_rd, wb_data,
        output jump, jump_pc, stall, id_ex_a, id_ex_b, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd, id_ex_shamt,
               id_ex_alu_op, id_ex_alu_src, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg
    );
endinterface

// File: rtl/id_stage_register_file.sv
// register_file: 32x32 registers, two async read ports, one sync write port, sync clear; r0 never written
module register_file (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  i_ra_a,
    input  logic [4:0]  i_ra_b,
    output logic [31:0] o_rd_a,
    output logic [31:0] o_rd_b,
    input  logic        i_we,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd
);
    logic [31:0] r_mem [32];
    assign o_rd_a = r_mem[i_ra_a];
    assign o_rd_b = r_mem[i_ra_b];
    always_ff @(posedge clock) begin
        if (reset) r_mem <= '{default: '0};
        else if (i_we && i_wa != '0) r_mem[i_wa] <= i_wd;
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: decode, bypassed register read, branch/jump resolution, hazard stall and the ID/EX register
module id_stage
    import cpu_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    id_stage_if.slave bus
);
    logic [31:0] w_ins, w_rf_a, w_rf_b, w_a, w_b, w_imm;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh, w_dst;
    logic [15:0] w_i16;
    alu_op_e     w_alu_op;
    logic w_valid, w_uses_rs, w_uses_rt, w_alu_src, w_mem_read, w_mem_write, w_reg_write;
    logic w_beq, w_bne, w_j, w_jal, w_jr, w_r3, w_rsh;
    logic w_src_ex, w_src_mem, w_stall, w_take, w_kill;
    assign w_ins = bus.if_id_instruction;
    assign {w_op, w_rs, w_rt, w_rd, w_sh, w_fn} = w_ins;
    assign w_i16 = w_ins[15:0];
    always_comb begin
        w_valid = 1'b0; w_uses_rs = 1'b0; w_uses_rt = 1'b0; w_dst = '0; w_alu_op = ALU_ADD;
        w_alu_src = 1'b0; w_mem_read = 1'b0; w_mem_write = 1'b0; w_reg_write = 1'b0;
        w_beq = 1'b0; w_bne = 1'b0; w_j = 1'b0; w_jal = 1'b0; w_jr = 1'b0; w_r3 = 1'b0; w_rsh = 1'b0;
        w_imm = {{16{w_i16[15]}}, w_i16};
        case (w_op)
            OP_R: begin
                w_r3 = w_fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR};
                w_rsh = w_fn inside {FN_SLL, FN_SRL, FN_SRA};
                w_jr = w_fn == FN_JR;
                w_alu_op = w_fn == FN_SUB ? ALU_SUB : w_fn == FN_AND ? ALU_AND : w_fn == FN_OR ? ALU_OR :
                           w_fn == FN_XOR ? ALU_XOR : w_fn == FN_SLL ? ALU_SLL : w_fn == FN_SRL ? ALU_SRL :
                           w_fn == FN_SRA ? ALU_SRA : ALU_ADD;
                w_valid = w_r3 | w_rsh | w_jr;
                w_uses_rs = w_r3 | w_jr;
                w_uses_rt = w_r3 | w_rsh;
                w_reg_write = w_r3 | w_rsh;
                w_dst = (w_r3 | w_rsh) ? w_rd : '0;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                w_valid = 1'b1; w_uses_rs = w_op != OP_LUI; w_dst = w_rt; w_reg_write = 1'b1; w_alu_src = 1'b1;
                w_mem_read = w_op == OP_LW;
                w_alu_op = w_op == OP_ANDI ? ALU_AND : w_op == OP_ORI ? ALU_OR : w_op == OP_XORI ? ALU_XOR :
                           w_op == OP_LUI ? ALU_LUI : ALU_ADD;
                if (w_op inside {OP_ANDI, OP_ORI, OP_XORI}) w_imm = {16'h0, w_i16};
                if (w_op == OP_LUI) w_imm = {w_i16, 16'h0};
            end
            OP_SW: begin
                w_valid = 1'b1; w_uses_rs = 1'b1; w_uses_rt = 1'b1; w_alu_src = 1'b1; w_mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_valid = 1'b1; w_uses_rs = 1'b1; w_uses_rt = 1'b1;
                w_beq = w_op == OP_BEQ; w_bne = w_op == OP_BNE;
            end
            OP_J: begin
                w_valid = 1'b1; w_j = 1'b1;
            end
            OP_JAL: begin
                w_valid = 1'b1; w_jal = 1'b1; w_reg_write = 1'b1; w_dst = REG_RA;
            end
            default: ;
        endcase
    end
    register_file u_rf (
        .clock (clock), .reset (reset),
        .i_ra_a (w_rs), .i_ra_b (w_rt), .o_rd_a (w_rf_a), .o_rd_b (w_rf_b),
        .i_we (bus.wb_write), .i_wa (bus.wb_rd), .i_wd (bus.wb_data)
    );
    // MEM result wins over the same-cycle write-back, which wins over the array
    assign w_a = w_rs == '0 ? '0 : (bus.ex_mem_reg_write && bus.ex_mem_rd == w_rs) ? bus.ex_mem_result :
                 (bus.wb_write && bus.wb_rd == w_rs) ? bus.wb_data : w_rf_a;
    assign w_b = w_rt == '0 ? '0 : (bus.ex_mem_reg_write && bus.ex_mem_rd == w_rt) ? bus.ex_mem_result :
                 (bus.wb_write && bus.wb_rd == w_rt) ? bus.wb_data : w_rf_b;
    assign w_src_ex = bus.id_ex_rd != '0 &&
                      ((w_uses_rs && w_rs == bus.id_ex_rd) || (w_uses_rt && w_rt == bus.id_ex_rd));
    assign w_src_mem = bus.ex_mem_rd != '0 &&
                       ((w_uses_rs && w_rs == bus.ex_mem_rd) || (w_uses_rt && w_rt == bus.ex_mem_rd));
    assign w_stall = (bus.id_ex_mem_read && w_src_ex) ||
                     ((w_beq | w_bne | w_jr) && ((bus.id_ex_reg_write && w_src_ex) ||
                                                 (bus.ex_mem_mem_read && w_src_mem)));
    assign w_take = w_j | w_jal | w_jr | (w_beq && w_a == w_b) | (w_bne && w_a != w_b);
    assign w_kill = w_stall | ~w_valid;
    assign bus.stall = w_stall;
    assign bus.jump = w_take & ~w_stall;
    assign bus.jump_pc = (w_beq | w_bne) ? bus.if_id_pc4 + {w_imm[29:0], 2'b00} :
                         w_jr ? w_a : {bus.if_id_pc4[31:28], w_ins[25:0], 2'b00};
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.id_ex_a <= '0; bus.id_ex_b <= '0; bus.id_ex_imm <= '0;
            bus.id_ex_rs <= '0; bus.id_ex_rt <= '0; bus.id_ex_rd <= '0; bus.id_ex_shamt <= '0;
            bus.id_ex_alu_op <= '0; bus.id_ex_alu_src <= 1'b0; bus.id_ex_mem_read <= 1'b0;
            bus.id_ex_mem_write <= 1'b0; bus.id_ex_reg_write <= 1'b0; bus.id_ex_mem_to_reg <= 1'b0;
        end else begin
            bus.id_ex_a <= w_kill ? '0 : w_jal ? bus.if_id_pc4 : w_a;
            bus.id_ex_b <= (w_kill | w_jal) ? '0 : w_b;
            bus.id_ex_imm <= w_kill ? '0 : w_imm;
            bus.id_ex_rs <= (w_kill | ~w_uses_rs) ? '0 : w_rs;
            bus.id_ex_rt <= (w_kill | ~w_uses_rt) ? '0 : w_rt;
            bus.id_ex_rd <= w_kill ? '0 : w_dst;
            bus.id_ex_shamt <= w_kill ? '0 : w_sh;
            bus.id_ex_alu_op <= w_kill ? '0 : w_alu_op;
            bus.id_ex_alu_src <= ~w_kill & w_alu_src;
            bus.id_ex_mem_read <= ~w_kill & w_mem_read;
            bus.id_ex_mem_write <= ~w_kill & w_mem_write;
            bus.id_ex_reg_write <= ~w_kill & w_reg_write;
            bus.id_ex_mem_to_reg <= ~w_kill & w_mem_read;
        end
    end
endmodule
